// File: rtl/irq_controller.sv
// Machine-level interrupt controller: owns mtime/mtimecmp/msip, builds mip,
// arbitrates one trap request to the pipeline and sequences WFI sleep.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no request outstanding, watching for an enabled pending bit
// ST_REQ   | irq_req high, irq_cause frozen until ack or withdrawal
// ST_DRAIN | trap taken, waiting for trap entry to clear mstatus.MIE
module irq_controller #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic        ext_irq,
  input  logic        global_mie,
  input  logic [31:0] mie,
  output logic [31:0] mip,
  output logic        irq_req,
  output logic [30:0] irq_cause,
  input  logic        irq_ack,
  input  logic        wfi,
  output logic        stall
);

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_REQ      = 2'd1;
  localparam logic [1:0]  ST_DRAIN    = 2'd2;
  localparam logic [15:0] PRESCALE_TC = 16'(PRESCALE - 1);

  logic [15:0] presc_cnt;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] mtime_inc;
  logic [31:0] mtime_lo_nxt;
  logic [31:0] mtime_hi_nxt;
  logic        msip;
  logic [1:0]  ext_sync;
  logic        mtip_q;
  logic        wr_en;
  logic [31:0] rd_mux;
  logic [31:0] enabled;
  logic        irq_pend;
  logic [30:0] cause_sel;
  logic [1:0]  state;

  assign tick      = (presc_cnt == PRESCALE_TC);
  assign mtime_inc = mtime + 64'd1;
  assign wr_en     = bus_valid & bus_we;

  // A bus write replaces only its own word; the other word keeps the carry.
  always_comb begin
    mtime_lo_nxt = tick ? mtime_inc[31:0]  : mtime[31:0];
    mtime_hi_nxt = tick ? mtime_inc[63:32] : mtime[63:32];
    if (wr_en && bus_addr == 3'd0) mtime_lo_nxt = bus_wdata;
    if (wr_en && bus_addr == 3'd1) mtime_hi_nxt = bus_wdata;
  end

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      3'd0:    rd_mux = mtime[31:0];
      3'd1:    rd_mux = mtime[63:32];
      3'd2:    rd_mux = mtimecmp[31:0];
      3'd3:    rd_mux = mtimecmp[63:32];
      3'd4:    rd_mux = {31'd0, msip};
      default: rd_mux = '0;
    endcase
  end

  assign mip      = {20'd0, ext_sync[1], 3'd0, mtip_q, 3'd0, msip, 3'd0};
  assign enabled  = mip & mie;
  assign irq_pend = |enabled;

  always_comb begin
    cause_sel = 31'd7;
    if (enabled[11])     cause_sel = 31'd11;
    else if (enabled[3]) cause_sel = 31'd3;
  end

  assign irq_req = (state == ST_REQ);
  // Wake-up deliberately ignores global_mie so WFI resumes without a trap.
  assign stall   = wfi & ~irq_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      ext_sync  <= '0;
      mtip_q    <= 1'b0;
      bus_ready <= 1'b0;
      bus_rdata <= '0;
    end else begin
      presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
      mtime     <= {mtime_hi_nxt, mtime_lo_nxt};
      if (wr_en && bus_addr == 3'd2) mtimecmp[31:0]  <= bus_wdata;
      if (wr_en && bus_addr == 3'd3) mtimecmp[63:32] <= bus_wdata;
      if (wr_en && bus_addr == 3'd4) msip            <= bus_wdata[0];
      ext_sync  <= {ext_sync[0], ext_irq};
      mtip_q    <= (mtime >= mtimecmp);
      bus_ready <= bus_valid;
      bus_rdata <= bus_valid ? rd_mux : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      irq_cause <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (global_mie && irq_pend) begin
            irq_cause <= cause_sel;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack)                       state <= ST_DRAIN;
          else if (!irq_pend || !global_mie) state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (!global_mie) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: bus reads and trap causes go through
// scoreboard queues checked by monitors; timing points are checked inline.
module tb_irq_controller;

  logic        clk;
  logic        rst_n;
  logic        bus_valid;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        ext_irq;
  logic        global_mie;
  logic [31:0] mie;
  logic [31:0] mip;
  logic        irq_req;
  logic [30:0] irq_cause;
  logic        irq_ack;
  logic        wfi;
  logic        stall;

  typedef struct {
    bit          is_rd;
    logic [31:0] d;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [30:0] irq_q[$];
  bus_exp_t    bus_e;
  logic [30:0] cause_e;
  logic        req_prev;
  int          n_vec;
  int          n_miss;
  int          cyc;

  irq_controller #(.PRESCALE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_valid  (bus_valid),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ready  (bus_ready),
    .ext_irq    (ext_irq),
    .global_mie (global_mie),
    .mie        (mie),
    .mip        (mip),
    .irq_req    (irq_req),
    .irq_cause  (irq_cause),
    .irq_ack    (irq_ack),
    .wfi        (wfi),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release; with PRESCALE = 1 this equals mtime
  // unless software has written it.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  always @(negedge clk) begin
    if (bus_ready) begin
      if (bus_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL bus_unexpected: got bus_ready=1, expected no outstanding access");
      end else begin
        bus_e = bus_q.pop_front();
        if (bus_e.is_rd) begin
          n_vec++;
          if (bus_rdata !== bus_e.d) begin
            n_miss++;
            $display("FAIL bus_rdata: got %h expected %h", bus_rdata, bus_e.d);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (irq_req && !req_prev) begin
      n_vec++;
      if (irq_q.size() == 0) begin
        n_miss++;
        $display("FAIL irq_unexpected: got irq_req=1 cause %0d, expected no request", irq_cause);
      end else begin
        cause_e = irq_q.pop_front();
        if (irq_cause !== cause_e) begin
          n_miss++;
          $display("FAIL irq_cause: got %0d expected %0d", irq_cause, cause_e);
        end
      end
    end
    req_prev <= irq_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic at_cyc(input int k);
    if (cyc > k) begin
      n_vec++;
      n_miss++;
      $display("FAIL schedule: got cycle %0d expected at most %0d", cyc, k);
    end
    while (cyc < k) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus_q.push_back('{is_rd: 1'b0, d: 32'd0});
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    @(negedge clk);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    bus_q.push_back('{is_rd: 1'b1, d: exp});
    bus_valid = 1'b1;
    bus_we    = 1'b0;
    bus_addr  = a;
    @(negedge clk);
    bus_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_miss = 0; cyc = 0; req_prev = 1'b0;
    rst_n = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    ext_irq = 1'b0; global_mie = 1'b0; mie = '0; irq_ack = 1'b0; wfi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mip", mip, 32'd0);
    chk("rst_irq_req", {31'd0, irq_req}, 32'd0);
    chk("rst_irq_cause", {1'b0, irq_cause}, 32'd0);
    chk("rst_bus_ready", {31'd0, bus_ready}, 32'd0);
    chk("rst_bus_rdata", bus_rdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;

    at_cyc(0);
    rd(3'd3, 32'hFFFF_FFFF);
    rd(3'd0, 32'd1);
    rd(3'd5, 32'd0);

    // Timer interrupt: mtimecmp = 20.
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd20);
    chk("tmr_mip_early", mip, 32'd0);
    mie = 32'h80; global_mie = 1'b1;
    irq_q.push_back(31'd7);
    at_cyc(20); chk("tmr_mip_at20", mip, 32'd0);
    at_cyc(21); chk("tmr_mip_rise", mip, 32'h80);
    chk("tmr_req_not_yet", {31'd0, irq_req}, 32'd0);
    at_cyc(22); chk("tmr_req", {31'd0, irq_req}, 32'd1);
    irq_ack = 1'b1;
    at_cyc(23); chk("tmr_ack_drop", {31'd0, irq_req}, 32'd0);
    irq_ack = 1'b0;
    at_cyc(25); chk("tmr_drain_hold", {31'd0, irq_req}, 32'd0);
    global_mie = 1'b0; mie = 32'd0;
    wr(3'd3, 32'hFFFF_FFFF);
    at_cyc(28); chk("tmr_mip_clear", mip, 32'd0);

    // Priority: all three pending and enabled.
    ext_irq = 1'b1; mie = 32'h888;
    wr(3'd4, 32'd1);
    wr(3'd3, 32'd0);
    at_cyc(33); chk("pri_mip_all", mip, 32'h888);
    irq_q.push_back(31'd11);
    global_mie = 1'b1;
    at_cyc(34); chk("pri_req", {31'd0, irq_req}, 32'd1);
    irq_ack = 1'b1;
    at_cyc(35);
    irq_ack = 1'b0; global_mie = 1'b0; ext_irq = 1'b0; mie = 32'h808;
    irq_q.push_back(31'd3);
    at_cyc(38); chk("pri_mip_no_meip", mip, 32'h088);
    global_mie = 1'b1;
    at_cyc(39); chk("pri_req_msi", {31'd0, irq_req}, 32'd1);

    // Withdrawal: clear msip while in REQ with no ack.
    wr(3'd4, 32'd0);
    chk("wd_req_held", {31'd0, irq_req}, 32'd1);
    chk("wd_cause_held", {1'b0, irq_cause}, 32'd3);
    at_cyc(41); chk("wd_req_drop", {31'd0, irq_req}, 32'd0);
    irq_q.push_back(31'd3);
    wr(3'd4, 32'd1);
    at_cyc(43); chk("wd2_req", {31'd0, irq_req}, 32'd1);
    irq_ack = 1'b1; global_mie = 1'b0;
    at_cyc(44); chk("wd2_ack_drop", {31'd0, irq_req}, 32'd0);
    irq_ack = 1'b0; global_mie = 1'b1;
    at_cyc(46); chk("wd2_in_drain", {31'd0, irq_req}, 32'd0);
    global_mie = 1'b0;
    wr(3'd4, 32'd0);

    // WFI sleep with global_mie = 0.
    at_cyc(48);
    wfi = 1'b1; mie = 32'h800;
    at_cyc(49); chk("wfi_stall", {31'd0, stall}, 32'd1);
    at_cyc(50); ext_irq = 1'b1;
    at_cyc(51); chk("wfi_stall_sync", {31'd0, stall}, 32'd1);
    at_cyc(52); chk("wfi_wake", {31'd0, stall}, 32'd0);
    chk("wfi_no_req", {31'd0, irq_req}, 32'd0);
    at_cyc(53); chk("wfi_no_req2", {31'd0, irq_req}, 32'd0);
    wfi = 1'b0; ext_irq = 1'b0; mie = 32'd0;

    // 64-bit wrap.
    at_cyc(56);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd1, 32'hFFFF_FFFF);
    rd(3'd0, 32'd0);
    chk("wrap_mip", mip, 32'd0);
    rd(3'd1, 32'd0);

    // Reset while in REQ.
    global_mie = 1'b1; mie = 32'h8;
    irq_q.push_back(31'd3);
    wr(3'd4, 32'd1);
    at_cyc(65); chk("rr_req", {31'd0, irq_req}, 32'd1);
    rst_n = 1'b0; global_mie = 1'b0; mie = 32'd0;
    @(negedge clk);
    chk("rr_req_drop", {31'd0, irq_req}, 32'd0);
    chk("rr_mip", mip, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(3'd3, 32'hFFFF_FFFF);
    rd(3'd4, 32'd0);
    rd(3'd0, 32'd2);

    repeat (3) @(negedge clk);
    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("irq_q_drained", irq_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Machine-level interrupt controller sitting between the platform (timer, software and external interrupt sources) and the CSR/trap unit of the core. It owns the 64-bit machine timer (`mtime`/`mtimecmp`) and the software-interrupt bit, and exposes them on a small word-addressed register bus. It produces the architectural `mip` view and raises a single prioritised trap request to the pipeline through a req/ack handshake. It also sequences WFI by stalling the core until an enabled interrupt is pending.

## Interface
- `PRESCALE`, default 1: `mtime` increments once every `PRESCALE` clk cycles; legal range 1..65535.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `bus_valid`  in  1  register access strobe.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  3  word index: 0 `mtime[31:0]`, 1 `mtime[63:32]`, 2 `mtimecmp[31:0]`, 3 `mtimecmp[63:32]`, 4 `msip` (bit 0); 5–7 reserved.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data, valid while `bus_ready` = 1.
- `bus_ready`  out  1  one-cycle completion pulse.
- `ext_irq`  in  1  asynchronous external interrupt, level-sensitive, active-high.
- `global_mie`  in  1  `mstatus.MIE` from the CSR unit.
- `mie`  in  32  CSR `mie`.
- `mip`  out  32  pending bits: [3] MSIP, [7] MTIP, [11] MEIP; all other bits 0.
- `irq_req`  out  1  trap request to the pipeline.
- `irq_cause`  out  31  exception code of the request (11, 3 or 7).
- `irq_ack`  in  1  pipeline accepted the trap this cycle.
- `wfi`  in  1  a WFI instruction is in execute.
- `stall`  out  1  hold the pipeline (WFI sleep).

## Operation
- **Reset values**
  - `mtime` = 0; `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF; `msip` = 0.
  - Prescaler count = 0; both synchroniser flops = 0.
  - FSM in IDLE.
  - All outputs are 0: `mip`, `irq_req`, `irq_cause`, `bus_ready`, `bus_rdata`, `stall`.
- **Timer**
  - The prescaler counts 0..`PRESCALE`-1. On wrap, `mtime` increments by 1.
  - `mtime` wraps modulo 2^64; a carry from the low word propagates into the high word in the same cycle.
  - A bus write to either `mtime` word in the tick cycle wins over the increment; the other word still receives the carry.
  - Each `mtimecmp` word is written independently. No atomicity is provided; software writes the high word to all-ones first.
- **Pending bits** (all registered)
  - MTIP = (`mtime` >= `mtimecmp`), 64-bit unsigned compare.
  - MSIP = `msip`.
  - MEIP = `ext_irq` after a 2-flop synchroniser.
- **Bus**
  - An access is captured on `bus_valid`. `bus_ready` pulses the next cycle.
  - Read data is sampled in the capture cycle, so it reflects pre-write values.
  - Reserved addresses read 0; writes to them are ignored.
  - `msip` writes use `bus_wdata[0]`.
  - Back-to-back accesses are allowed, one per cycle.
- **Arbitration**
  - enabled = `mip` & `mie`.
  - Priority: MEI (11) > MSI (3) > MTI (7).
- **FSM states**
  - IDLE
    - If `global_mie` and enabled != 0: latch the highest-priority cause into `irq_cause` and go to REQ.
  - REQ (`irq_req` = 1, `irq_cause` held stable)
    - `irq_ack` = 1: go to DRAIN. The ack takes priority over any simultaneous withdrawal.
    - Else, if enabled == 0 or `global_mie` = 0: withdraw and go to IDLE. `irq_req` drops the next cycle.
    - A higher-priority source arriving while in REQ does not change `irq_cause`.
  - DRAIN
    - Wait for `global_mie` = 0 (trap entry cleared MIE), then go to IDLE.
    - This prevents a duplicate request before the CSR update is visible.
- **WFI**
  - `stall` = `wfi` & (enabled == 0), evaluated combinationally from the registered `mip`.
  - Wake-up ignores `global_mie`.
  - With `global_mie` = 0, the core resumes after WFI without a trap.
- **Reset mid-operation**
  - Any state returns to IDLE and all registers take their reset values.
  - An outstanding `irq_req` drops the cycle after `rst_n` is sampled low.

## Timing
- `ext_irq` rise → MEIP = 1: 2 cycles.
- MEIP = 1 → `irq_req` = 1: +1 cycle, given the enables are set.
- Compare to MTIP: 1 cycle after the `mtime`/`mtimecmp` update.
- `irq_ack` → `irq_req` low: the next cycle.
- A new request is possible no earlier than 1 cycle after `global_mie` returns high.
- `bus_valid` → `bus_ready`/`bus_rdata`: 1 cycle.
- A written value is visible in `mtime` the next cycle; MTIP reflects it 1 cycle later.

## Test plan
- **Reset**
  - Stimulus: hold `rst_n` = 0 for 3 cycles, then read address 3.
  - Response: `bus_rdata` = 32'hFFFF_FFFF and `mip` = 0. With `PRESCALE` = 1, reading address 0 yields the elapsed cycle count.
- **Timer interrupt**
  - Stimulus: write `mtimecmp` = 20 (high word first, 0), `mie[7]` = 1, `global_mie` = 1.
  - Response:
    - MTIP rises the cycle after `mtime` reaches 20.
    - `irq_req` = 1 with `irq_cause` = 7 one cycle later.
    - Ack → `irq_req` = 0 next cycle; FSM stays in DRAIN until `global_mie` = 0.
- **Priority**
  - Stimulus: MSIP, MTIP and MEIP all pending and enabled.
  - Response: `irq_cause` = 11. After ack, with MEIP cleared and MIE restored, the next request has `irq_cause` = 3.
- **Withdrawal**
  - Stimulus: in REQ (cause 3), write `msip` = 0 with no ack.
  - Response: `irq_req` drops after MSIP clears; FSM returns to IDLE.
  - Also: ack and withdrawal in the same cycle → DRAIN.
- **WFI**
  - Stimulus: `wfi` = 1, `global_mie` = 0, `mie[11]` = 1, `ext_irq` low.
  - Response:
    - `stall` = 1 until 2 cycles after `ext_irq` rises, then `stall` = 0.
    - `irq_req` stays 0 throughout.
- **Wrap and reset**
  - Stimulus 1: write `mtime` = 64'hFFFF_FFFF_FFFF_FFFF. Response: next tick gives `mtime` = 0 with MTIP = 0.
  - Stimulus 2: assert `rst_n` = 0 while in REQ. Response: `irq_req` = 0 the next cycle.
